// File: rtl/dac_ctrl_pkg.sv
// Shared types and helpers for the HV-bias DAC serial controller.
// Frame/address widths, FSM state encoding and the frame word builder.
package dac_ctrl_pkg;

  localparam int FRAME_W = 16;
  localparam int ADDR_W  = 4;
  localparam int CODE_W  = 12;

  typedef enum logic [2:0] {
    IDLE,
    SNAP,
    SHIFT,
    GAP,
    LOAD
  } dac_state_e;

  // code is left-aligned in its 12-bit field by the caller
  function automatic logic [FRAME_W-1:0] build_frame(
    input logic [ADDR_W-1:0] addr,
    input logic [CODE_W-1:0] code
  );
    return {addr, code};
  endfunction

endpackage

// File: rtl/dac_frame_piso.sv
// 16-bit parallel-load, MSB-first serial shift register for one DAC.
// Ports: dac_sclk_i/reset, load_i + word_i (parallel load), shift_en_i, sdo_o.
module dac_frame_piso
  import dac_ctrl_pkg::*;
(
  input  logic               dac_sclk_i,
  input  logic               reset,
  input  logic               load_i,
  input  logic               shift_en_i,
  input  logic [FRAME_W-1:0] word_i,
  output logic               sdo_o
);

  logic [FRAME_W-1:0] sr_q;

  always_ff @(posedge dac_sclk_i or negedge reset) begin
    if (!reset) begin
      sr_q <= '0;
    end else if (load_i) begin
      sr_q <= word_i;
    end else if (shift_en_i) begin
      sr_q <= {sr_q[FRAME_W-2:0], 1'b0};
    end
  end

  assign sdo_o = sr_q[FRAME_W-1];

endmodule

// File: rtl/hv_dac_multi_ctrl.sv
// Serial controller driving N_DAC HV-bias DACs in parallel: snapshot, frames, LDAC.
// Ports: dac_sclk_i/reset, hv_update, hv_reg_din, dac_dout -> dac_sclk, dac_din,
// dac_cs, dac_load, busy, done, rb_err. Option macro: DAC_READBACK_EN.
module hv_dac_multi_ctrl
  import dac_ctrl_pkg::*;
#(
  parameter int               N_DAC     = 4,
  parameter int               N_CH      = 8,
  parameter int               DATA_W    = 10,
  parameter int               ADDR_BASE = 2,
  parameter logic [FRAME_W-1:0] CTRL_WORD = 16'h00FF,
  parameter int               GAP_CYC   = 4,
  parameter int               LOAD_CYC  = 16
) (
  input  logic                          dac_sclk_i,
  input  logic                          reset,
  input  logic                          hv_update,
  input  logic [N_DAC*N_CH*DATA_W-1:0]  hv_reg_din,
  input  logic [N_DAC-1:0]              dac_dout,
  output logic [N_DAC-1:0]              dac_sclk,
  output logic [N_DAC-1:0]              dac_din,
  output logic [N_DAC-1:0]              dac_cs,
  output logic                          dac_load,
  output logic                          busy,
  output logic                          done,
  output logic [N_DAC-1:0]              rb_err
);

  localparam int TOT_W = N_DAC * N_CH * DATA_W;
  localparam int SH    = CODE_W - DATA_W;
  localparam int CMAX0 = (LOAD_CYC > GAP_CYC) ? LOAD_CYC : GAP_CYC;
  localparam int CMAX  = (CMAX0 > FRAME_W) ? CMAX0 : FRAME_W;
  localparam int CW    = $clog2(CMAX);
  localparam int FCW   = (N_CH + 1 > 2) ? $clog2(N_CH + 1) : 1;

  localparam logic [CW-1:0]  SH_LAST  = CW'(FRAME_W - 1);
  localparam logic [CW-1:0]  GAP_LAST = CW'(GAP_CYC - 1);
  localparam logic [CW-1:0]  LD_LAST  = CW'(LOAD_CYC - 1);
  localparam logic [FCW-1:0] F_LAST   = FCW'(N_CH);

  dac_state_e        state_q;
  logic [CW-1:0]     cnt_q;
  logic [FCW-1:0]    frm_q;
  logic              pend_q;
  logic              cs_q;
  logic              load_q;
  logic              busy_q;
  logic              done_q;
  logic [TOT_W-1:0]  snap_q;

  logic              gap_end;
  logic              sh_end;
  logic              frm_last;
  logic              piso_ld;
  logic              piso_sh;
  logic [FCW-1:0]    ch_sel;
  logic [ADDR_W-1:0] addr;
  logic [N_DAC-1:0]  sdo;

  assign gap_end  = (state_q == GAP) && (cnt_q == GAP_LAST);
  assign sh_end   = (state_q == SHIFT) && (cnt_q == SH_LAST);
  assign frm_last = (frm_q == F_LAST);
  assign piso_ld  = (state_q == SNAP) || (gap_end && !frm_last);
  assign piso_sh  = (state_q == SHIFT);

  // next frame after frame f carries channel f
  assign ch_sel = (frm_q < F_LAST) ? frm_q : '0;
  assign addr   = ADDR_W'(ADDR_BASE + int'(ch_sel));

  always_ff @(posedge dac_sclk_i or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      frm_q   <= '0;
      pend_q  <= 1'b0;
      cs_q    <= 1'b1;
      load_q  <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (hv_update || pend_q) begin
            state_q <= SNAP;
            busy_q  <= 1'b1;
            pend_q  <= 1'b0;
          end
        end
        SNAP: begin
          state_q <= SHIFT;
          cs_q    <= 1'b0;
          cnt_q   <= '0;
          frm_q   <= '0;
        end
        SHIFT: begin
          if (cnt_q == SH_LAST) begin
            state_q <= GAP;
            cs_q    <= 1'b1;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        GAP: begin
          if (cnt_q == GAP_LAST) begin
            cnt_q <= '0;
            if (frm_last) begin
              state_q <= LOAD;
              load_q  <= 1'b0;
            end else begin
              state_q <= SHIFT;
              cs_q    <= 1'b0;
              frm_q   <= frm_q + FCW'(1);
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        LOAD: begin
          if (cnt_q == LD_LAST) begin
            state_q <= IDLE;
            load_q  <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          cs_q    <= 1'b1;
          load_q  <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
      // requests while busy (incl. the LOAD->IDLE edge) coalesce here
      if (state_q != IDLE && hv_update) begin
        pend_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge dac_sclk_i or negedge reset) begin
    if (!reset) begin
      snap_q <= '0;
    end else if (state_q == SNAP) begin
      snap_q <= hv_reg_din;
    end
  end

  for (genvar d = 0; d < N_DAC; d++) begin : g_dac
    logic [DATA_W-1:0]  code;
    logic [FRAME_W-1:0] word;

    assign code = snap_q[(d*N_CH + int'(ch_sel))*DATA_W +: DATA_W];
    assign word = (state_q == SNAP) ? CTRL_WORD
                : build_frame(addr, CODE_W'(code) << SH);

    dac_frame_piso u_piso (
      .dac_sclk_i (dac_sclk_i),
      .reset      (reset),
      .load_i     (piso_ld),
      .shift_en_i (piso_sh),
      .word_i     (word),
      .sdo_o      (sdo[d])
    );

    assign dac_din[d] = sdo[d] & ~cs_q;

`ifdef DAC_READBACK_EN
    logic [FRAME_W-1:0] rx_q;
    logic [FRAME_W-1:0] cur_q;
    logic [FRAME_W-1:0] prev_q;
    logic [FRAME_W-1:0] rx_d;
    logic               rb_q;

    // DAC echoes the previous frame on SDO while the new one shifts in
    assign rx_d = {rx_q[FRAME_W-2:0], dac_dout[d]};

    always_ff @(posedge dac_sclk_i or negedge reset) begin
      if (!reset) begin
        rx_q   <= '0;
        cur_q  <= '0;
        prev_q <= '0;
        rb_q   <= 1'b0;
      end else begin
        if (piso_ld) begin
          cur_q  <= word;
          prev_q <= cur_q;
        end
        if (piso_sh) begin
          rx_q <= rx_d;
        end
        if (state_q == SNAP) begin
          rb_q <= 1'b0;
        end else if (sh_end && frm_q != '0 && rx_d != prev_q) begin
          rb_q <= 1'b1;
        end
      end
    end

    assign rb_err[d] = rb_q;
`else
    assign rb_err[d] = 1'b0;
`endif
  end

`ifndef DAC_READBACK_EN
  logic unused_dout;
  assign unused_dout = ^dac_dout;
`endif

  assign dac_sclk = {N_DAC{dac_sclk_i}};
  assign dac_cs   = {N_DAC{cs_q}};
  assign dac_load = load_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_hv_dac_multi_ctrl.sv
// Directed self-checking bench for hv_dac_multi_ctrl (default and small config).
// Readback checks expect rb_err activity only when DAC_READBACK_EN is defined.
module tb_hv_dac_multi_ctrl;

  logic         clk;
  logic         rst_n;
  logic         upd0;
  logic [319:0] din0;
  logic [319:0] alt_bus;
  logic [3:0]   dout0;
  logic [3:0]   sclk0;
  logic [3:0]   dino0;
  logic [3:0]   cs0;
  logic         load0;
  logic         busy0;
  logic         done0;
  logic [3:0]   rb0;

  logic         upd1;
  logic [71:0]  din1;
  logic [1:0]   dout1;
  logic [1:0]   sclk1;
  logic [1:0]   dino1;
  logic [1:0]   cs1;
  logic         load1;
  logic         busy1;
  logic         done1;
  logic [1:0]   rb1;

  int checks = 0;
  int errors = 0;

  int busy_n, done_n, first_done, second_done;
  int bad_cs, bad_load, bad_busy, bad_din, cs_falls;
  logic [3:0]  rb_k0, rb_k1, rb_k196;
  logic [15:0] words [4][9];
  logic [15:0] words1 [2][4];
  logic [15:0] lb [4];
  logic [3:0]  flip;
  logic [3:0]  rb_exp;

  hv_dac_multi_ctrl u0 (
    .dac_sclk_i (clk),
    .reset      (rst_n),
    .hv_update  (upd0),
    .hv_reg_din (din0),
    .dac_dout   (dout0),
    .dac_sclk   (sclk0),
    .dac_din    (dino0),
    .dac_cs     (cs0),
    .dac_load   (load0),
    .busy       (busy0),
    .done       (done0),
    .rb_err     (rb0)
  );

  hv_dac_multi_ctrl #(
    .N_DAC     (2),
    .N_CH      (3),
    .DATA_W    (12),
    .ADDR_BASE (14)
  ) u1 (
    .dac_sclk_i (clk),
    .reset      (rst_n),
    .hv_update  (upd1),
    .hv_reg_din (din1),
    .dac_dout   (dout1),
    .dac_sclk   (sclk1),
    .dac_din    (dino1),
    .dac_cs     (cs1),
    .dac_load   (load1),
    .busy       (busy1),
    .done       (done1),
    .rb_err     (rb1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // loopback DAC model: 16-bit SR clocked only while cs is low
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int d = 0; d < 4; d++) lb[d] <= '0;
    end else if (!cs0[0]) begin
      for (int d = 0; d < 4; d++) lb[d] <= {lb[d][14:0], dino0[d]};
    end
  end

  always_comb begin
    dout0 = '0;
    for (int d = 0; d < 4; d++) dout0[d] = lb[d][15] ^ flip[d];
  end

  assign dout1 = 2'b00;

  task automatic fill_bus(input logic [9:0] v);
    for (int i = 0; i < 32; i++) din0[i*10 +: 10] = v;
  endtask

  task automatic run_seq(input int ncyc, input int chg_at, input int ua,
                         input int ub, input int uc, input int flip_at);
    int   f;
    int   i;
    logic pcs;
    logic exp_low;
    busy_n = 0; done_n = 0; first_done = -1; second_done = -1;
    bad_cs = 0; bad_load = 0; bad_busy = 0; bad_din = 0; cs_falls = 0;
    pcs = 1'b1;
    for (int d = 0; d < 4; d++)
      for (int g = 0; g < 9; g++) words[d][g] = '0;
    @(negedge clk);
    upd0 = 1'b1;
    @(negedge clk);
    for (int k = 0; k < ncyc; k++) begin
      if (busy0) busy_n++;
      if (done0) begin
        done_n++;
        if (first_done < 0) first_done = k;
        else if (second_done < 0) second_done = k;
      end
      if (pcs && !cs0[0]) cs_falls++;
      pcs = cs0[0];
      if (k < 197) begin
        exp_low = (k >= 1) && (k <= 180) && (((k - 1) % 20) < 16);
        if (cs0 !== (exp_low ? 4'h0 : 4'hF)) bad_cs++;
        if (load0 !== !((k >= 181) && (k <= 196))) bad_load++;
        if (busy0 !== 1'b1) bad_busy++;
      end
      if (cs0[0] && dino0 !== 4'h0) bad_din++;
      if (k >= 1 && k <= 180 && !cs0[0]) begin
        f = (k - 1) / 20;
        i = (k - 1) % 20;
        if (i < 16)
          for (int d = 0; d < 4; d++) words[d][f][15-i] = dino0[d];
      end
      if (k == 0) rb_k0 = rb0;
      if (k == 1) rb_k1 = rb0;
      if (k == 196) rb_k196 = rb0;
      upd0 = (k == ua) || (k == ub) || (k == uc);
      flip = (k == flip_at) ? 4'b0010 : 4'b0000;
      if (k == chg_at) din0 = alt_bus;
      @(negedge clk);
    end
    upd0 = 1'b0;
    flip = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({cs0, dino0, load0, busy0, done0, rb0} !== {4'hF, 4'h0, 3'b100, 4'h0}) begin
      errors++;
      $display("FAIL reset_u0: got cs=%h din=%h ld=%b bsy=%b dn=%b rb=%h want F 0 1 0 0 0",
               cs0, dino0, load0, busy0, done0, rb0);
    end
    checks++;
    if ({cs1, dino1, load1, busy1, done1, rb1} !== {2'b11, 2'b00, 3'b100, 2'b00}) begin
      errors++;
      $display("FAIL reset_u1: got cs=%b din=%b ld=%b bsy=%b dn=%b rb=%b",
               cs1, dino1, load1, busy1, done1, rb1);
    end
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    checks++;
    if (busy0 !== 1'b0 || cs0 !== 4'hF) begin
      errors++;
      $display("FAIL idle_after_reset: got busy=%b cs=%h want 0 F", busy0, cs0);
    end
    checks++;
    if (sclk0 !== 4'h0) begin
      errors++;
      $display("FAIL sclk_low: got %h want 0", sclk0);
    end
    @(posedge clk);
    #1;
    checks++;
    if (sclk0 !== 4'hF) begin
      errors++;
      $display("FAIL sclk_high: got %h want F", sclk0);
    end
  endtask

  task automatic test_single_seq();
    fill_bus(10'h155);
    run_seq(210, -1, -1, -1, -1, -1);
    checks++;
    if (cs_falls !== 9) begin
      errors++;
      $display("FAIL cs_falls: got %0d want 9", cs_falls);
    end
    checks++;
    if (bad_cs !== 0) begin
      errors++;
      $display("FAIL cs_pattern: got %0d bad cycles want 0", bad_cs);
    end
    checks++;
    if (words[0][0] !== 16'h00FF) begin
      errors++;
      $display("FAIL frame0: got %h want 00ff", words[0][0]);
    end
    checks++;
    if (words[0][1] !== 16'h2554) begin
      errors++;
      $display("FAIL frame1: got %h want 2554", words[0][1]);
    end
    checks++;
    if (words[3][8] !== 16'h9554) begin
      errors++;
      $display("FAIL frame8_dac3: got %h want 9554", words[3][8]);
    end
    checks++;
    if (bad_load !== 0) begin
      errors++;
      $display("FAIL load_pattern: got %0d bad cycles want 0", bad_load);
    end
    checks++;
    if (first_done !== 197 || done_n !== 1) begin
      errors++;
      $display("FAIL done_time: got k=%0d n=%0d want 197 1", first_done, done_n);
    end
    checks++;
    if (busy_n !== 197 || bad_busy !== 0) begin
      errors++;
      $display("FAIL busy_len: got %0d bad=%0d want 197 0", busy_n, bad_busy);
    end
    checks++;
    if (bad_din !== 0) begin
      errors++;
      $display("FAIL din_idle: got %0d bad cycles want 0", bad_din);
    end
    checks++;
    if (rb_k196 !== 4'h0) begin
      errors++;
      $display("FAIL rb_clean: got %b want 0000", rb_k196);
    end
  endtask

  task automatic test_snapshot();
    fill_bus(10'h155);
    din0[17*10 +: 10] = 10'h2A7;
    for (int i = 0; i < 32; i++) alt_bus[i*10 +: 10] = 10'h3FF;
    alt_bus[17*10 +: 10] = 10'h0F0;
    run_seq(210, 1, -1, -1, -1, -1);
    checks++;
    if (words[2][2] !== 16'h3A9C) begin
      errors++;
      $display("FAIL snap_dac2_ch1: got %h want 3a9c", words[2][2]);
    end
    checks++;
    if (words[0][1] !== 16'h2554) begin
      errors++;
      $display("FAIL snap_dac0_ch0: got %h want 2554", words[0][1]);
    end
  endtask

  task automatic test_back_to_back();
    fill_bus(10'h155);
    run_seq(420, -1, 30, 90, 150, -1);
    checks++;
    if (done_n !== 2 || second_done !== 395) begin
      errors++;
      $display("FAIL b2b_done: got n=%0d k2=%0d want 2 395", done_n, second_done);
    end
    checks++;
    if (busy_n !== 394) begin
      errors++;
      $display("FAIL b2b_busy: got %0d want 394", busy_n);
    end
  endtask

  task automatic test_update_at_load_end();
    run_seq(420, -1, 196, -1, -1, -1);
    checks++;
    if (done_n !== 2 || second_done !== 395 || busy_n !== 394) begin
      errors++;
      $display("FAIL edge_update: got n=%0d k2=%0d busy=%0d want 2 395 394",
               done_n, second_done, busy_n);
    end
  endtask

  task automatic test_reset_mid();
    int qbad;
    qbad = 0;
    @(negedge clk);
    upd0 = 1'b1;
    @(negedge clk);
    upd0 = 1'b0;
    repeat (85) @(negedge clk);
    checks++;
    if (cs0 !== 4'h0) begin
      errors++;
      $display("FAIL mid_frame4_cs: got %h want 0", cs0);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (cs0 !== 4'hF || load0 !== 1'b1 || busy0 !== 1'b0 || dino0 !== 4'h0) begin
      errors++;
      $display("FAIL async_reset: got cs=%h ld=%b busy=%b din=%h want F 1 0 0",
               cs0, load0, busy0, dino0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (busy0 || cs0 !== 4'hF || load0 !== 1'b1 || done0) qbad++;
    end
    checks++;
    if (qbad !== 0) begin
      errors++;
      $display("FAIL quiet_after_reset: got %0d bad cycles want 0", qbad);
    end
  endtask

  task automatic test_readback();
`ifdef DAC_READBACK_EN
    rb_exp = 4'b0010;
`else
    rb_exp = 4'b0000;
`endif
    fill_bus(10'h155);
    run_seq(210, -1, -1, -1, -1, 45);
    checks++;
    if (rb_k196 !== rb_exp) begin
      errors++;
      $display("FAIL rb_flip: got %b want %b", rb_k196, rb_exp);
    end
    run_seq(210, -1, -1, -1, -1, -1);
    checks++;
    if (rb_k0 !== rb_exp) begin
      errors++;
      $display("FAIL rb_sticky: got %b want %b", rb_k0, rb_exp);
    end
    checks++;
    if (rb_k1 !== 4'b0000 || rb_k196 !== 4'b0000) begin
      errors++;
      $display("FAIL rb_clear: got %b/%b want 0000/0000", rb_k1, rb_k196);
    end
  endtask

  task automatic test_wide_cfg();
    int f;
    int i;
    int b_n;
    int d_k;
    b_n = 0;
    d_k = -1;
    for (int d = 0; d < 2; d++)
      for (int g = 0; g < 4; g++) words1[d][g] = '0;
    din1 = {12'hABC, 12'hABC, 12'hABC, 12'hABC, 12'h456, 12'h123};
    @(negedge clk);
    upd1 = 1'b1;
    @(negedge clk);
    upd1 = 1'b0;
    for (int k = 0; k < 110; k++) begin
      if (busy1) b_n++;
      if (done1 && d_k < 0) d_k = k;
      if (k >= 1 && k <= 80 && !cs1[0]) begin
        f = (k - 1) / 20;
        i = (k - 1) % 20;
        if (i < 16)
          for (int d = 0; d < 2; d++) words1[d][f][15-i] = dino1[d];
      end
      @(negedge clk);
    end
    checks++;
    if (words1[0][1] !== 16'hE123 || words1[0][2] !== 16'hF456) begin
      errors++;
      $display("FAIL wide_f1f2: got %h %h want e123 f456", words1[0][1], words1[0][2]);
    end
    checks++;
    if (words1[0][3] !== 16'h0ABC || words1[1][3] !== 16'h0ABC) begin
      errors++;
      $display("FAIL wide_addr_wrap: got %h %h want 0abc 0abc", words1[0][3], words1[1][3]);
    end
    checks++;
    if (words1[1][0] !== 16'h00FF) begin
      errors++;
      $display("FAIL wide_ctrl: got %h want 00ff", words1[1][0]);
    end
    checks++;
    if (d_k !== 97 || b_n !== 97) begin
      errors++;
      $display("FAIL wide_len: got done=%0d busy=%0d want 97 97", d_k, b_n);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    upd0  = 1'b0;
    upd1  = 1'b0;
    din0  = '0;
    din1  = '0;
    alt_bus = '0;
    flip  = '0;
    test_reset();
    test_single_seq();
    test_snapshot();
    test_back_to_back();
    test_update_at_load_end();
    test_reset_mid();
    test_readback();
    test_wide_cfg();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
